// File: rtl/kuznechik_stream_wrapper_if.sv
// Byte-stream bus bundle for kuznechik_stream_wrapper.
//   s_data/s_valid/s_ready : plaintext byte input (valid/ready handshake)
//   m_data/m_valid/m_ready : ciphertext byte output (valid/ready handshake)
//   m_last                 : marks the 16th output byte of a block
// slave modport is the wrapper side, master modport is the byte source/sink side.
interface kuznechik_stream_wrapper_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport slave (
    input  s_data,
    input  s_valid,
    input  m_ready,
    output s_ready,
    output m_data,
    output m_valid,
    output m_last
  );

  modport master (
    output s_data,
    output s_valid,
    output m_ready,
    input  s_ready,
    input  m_data,
    input  m_valid,
    input  m_last
  );
endinterface

// File: rtl/kuznechik_stream_wrapper.sv
// Byte-stream front/back end for the Kuznechik encrypt core.
// Packs 16 input bytes (big-endian) into a 128-bit block, pulses enc_en, waits for
// enc_ready, then streams the 128-bit ciphertext out as 16 bytes. Half-duplex.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   keys_ready        : round keys valid; gates input acceptance
//   strm              : byte-stream bus (s_* in, m_* out, m_last)
//   enc_en            : one-cycle start pulse to the core
//   enc_in_data       : plaintext block to the core
//   enc_out_data      : ciphertext from the core
//   enc_ready         : core done, sampled only while waiting
//   busy              : any state other than idle-empty load
//   timeout_err       : sticky, set when the core never answers
module kuznechik_stream_wrapper #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        keys_ready,
  kuznechik_stream_wrapper_if.slave   strm,
  output logic                        enc_en,
  output logic [127:0]                enc_in_data,
  input  logic [127:0]                enc_out_data,
  input  logic                        enc_ready,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StSend  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]      send_cnt_q, send_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [127:0]    pt_q, pt_d;
  logic [127:0]    ct_q, ct_d;
  logic            timeout_err_q, timeout_err_d;

  logic s_hs;
  logic m_hs;
  logic to_hit;
  logic core_done;

  assign s_hs   = (state_q == StLoad) & keys_ready & strm.s_valid;
  assign m_hs   = (state_q == StSend) & strm.m_ready;
  // Counter value in the last permitted wait cycle.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  // enc_ready is ignored in the first wait cycle (counter still zero).
  assign core_done = (state_q == StWait) & enc_ready & (to_cnt_q != '0);

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    send_cnt_d    = send_cnt_q;
    to_cnt_d      = to_cnt_q;
    pt_d          = pt_q;
    ct_d          = ct_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      StLoad: begin
        if (s_hs) begin
          // Byte n lands at bits [127-8n -: 8]; ~cnt is 15-cnt.
          pt_d[{~byte_cnt_q, 3'b000} +: 8] = strm.s_data;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd0) begin
            timeout_err_d = 1'b0;
          end
          if (byte_cnt_q == 4'd15) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (core_done) begin
          ct_d       = enc_out_data;
          send_cnt_d = 4'd0;
          state_d    = StSend;
        end else if (to_hit) begin
          timeout_err_d = 1'b1;
          byte_cnt_d    = 4'd0;
          state_d       = StLoad;
        end
      end
      StSend: begin
        if (m_hs) begin
          ct_d       = {ct_q[119:0], 8'h00};
          send_cnt_d = send_cnt_q + 4'd1;
          if (send_cnt_q == 4'd15) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StLoad;
      byte_cnt_q    <= 4'd0;
      send_cnt_q    <= 4'd0;
      to_cnt_q      <= '0;
      pt_q          <= '0;
      ct_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      send_cnt_q    <= send_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pt_q          <= pt_d;
      ct_q          <= ct_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // s_ready is masked by rst so it reads low while reset is held.
  assign strm.s_ready = (state_q == StLoad) & keys_ready & ~rst;
  assign strm.m_valid = (state_q == StSend);
  assign strm.m_last  = (state_q == StSend) & (send_cnt_q == 4'd15);
  assign strm.m_data  = (state_q == StSend) ? ct_q[127:120] : 8'h00;
  assign enc_en       = (state_q == StStart);
  assign enc_in_data  = pt_q;
  assign busy         = ~((state_q == StLoad) & (byte_cnt_q == 4'd0));
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_kuznechik_stream_wrapper.sv
// Self-checking bench for kuznechik_stream_wrapper. Two instances share the stimulus:
// dut0 with the default timeout, dut1 with a 16-cycle timeout; sel picks the active one.
// A small behavioural core answers enc_en with enc_ready after core_lat cycles.
module tb_kuznechik_stream_wrapper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         keys_ready;
  logic         sel;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         m_ready;
  logic         enc_ready;
  logic [127:0] enc_out_data;

  kuznechik_stream_wrapper_if if0 ();
  kuznechik_stream_wrapper_if if1 ();

  assign if0.s_data  = s_data;
  assign if0.s_valid = s_valid & ~sel;
  assign if0.m_ready = m_ready & ~sel;
  assign if1.s_data  = s_data;
  assign if1.s_valid = s_valid & sel;
  assign if1.m_ready = m_ready & sel;

  logic         en0, en1, busy0, busy1, te0, te1;
  logic [127:0] in0, in1;

  kuznechik_stream_wrapper dut0 (
    .clk          (clk),
    .rst          (rst),
    .keys_ready   (keys_ready),
    .strm         (if0),
    .enc_en       (en0),
    .enc_in_data  (in0),
    .enc_out_data (enc_out_data),
    .enc_ready    (enc_ready),
    .busy         (busy0),
    .timeout_err  (te0)
  );

  kuznechik_stream_wrapper #(
    .TIMEOUT_CYCLES (16),
    .TO_W           (5)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .keys_ready   (keys_ready),
    .strm         (if1),
    .enc_en       (en1),
    .enc_in_data  (in1),
    .enc_out_data (enc_out_data),
    .enc_ready    (enc_ready),
    .busy         (busy1),
    .timeout_err  (te1)
  );

  logic         obs_s_ready, obs_m_valid, obs_m_last, obs_enc_en, obs_busy, obs_te;
  logic [7:0]   obs_m_data;
  logic [127:0] obs_in;
  assign obs_s_ready = sel ? if1.s_ready : if0.s_ready;
  assign obs_m_valid = sel ? if1.m_valid : if0.m_valid;
  assign obs_m_last  = sel ? if1.m_last  : if0.m_last;
  assign obs_m_data  = sel ? if1.m_data  : if0.m_data;
  assign obs_enc_en  = sel ? en1 : en0;
  assign obs_busy    = sel ? busy1 : busy0;
  assign obs_te      = sel ? te1 : te0;
  assign obs_in      = sel ? in1 : in0;

  // Behavioural encrypt core: ready pulse core_lat cycles after the start pulse.
  int           core_lat;
  int           core_cnt;
  logic         core_armed;
  logic [127:0] next_ct;
  int           en_pulses = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_armed <= 1'b0;
      core_cnt   <= 0;
    end else if (obs_enc_en) begin
      core_armed <= 1'b1;
      core_cnt   <= core_lat;
    end else if (core_armed) begin
      if (core_cnt == 0) core_armed <= 1'b0;
      else               core_cnt   <= core_cnt - 1;
    end
  end
  assign enc_ready    = core_armed && (core_cnt == 0);
  assign enc_out_data = next_ct;

  always @(posedge clk) if (obs_enc_en) en_pulses <= en_pulses + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
    return 8'(v >> (8 * (15 - k)));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_reset(input string w);
    chk({w, "_s_ready"}, obs_s_ready, 0);
    chk({w, "_m_valid"}, obs_m_valid, 0);
    chk({w, "_m_last"}, obs_m_last, 0);
    chk({w, "_m_data"}, obs_m_data, 0);
    chk({w, "_enc_en"}, obs_enc_en, 0);
    chk({w, "_enc_in_data"}, obs_in, 0);
    chk({w, "_busy"}, obs_busy, 0);
    chk({w, "_timeout_err"}, obs_te, 0);
  endtask

  // Entered and left at negedge+1.
  task automatic push(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    #1;
    while (!obs_s_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("push_accept", obs_s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
  endtask

  task automatic push_block(input logic [127:0] pt);
    for (int k = 0; k < 16; k++) begin
      push(byte_of(pt, k));
      if (k == 0) chk("te_clear_on_first_byte", obs_te, 0);
    end
  endtask

  task automatic collect(input logic [127:0] ct, input bit bp, input int exp_first);
    int i = 0;
    int cyc = 0;
    int first = -1;
    while (i < 16 && cyc < 2000) begin
      @(negedge clk);
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (obs_m_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_m_valid_cycle", first, exp_first);
        end
        chk("m_data", obs_m_data, byte_of(ct, i));
        chk("m_last", obs_m_last, (i == 15));
        if (m_ready) i++;
      end else if (first >= 0) begin
        chk("m_valid_hold", obs_m_valid, 1);
      end
    end
    chk("bytes_sent", i, 16);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("m_valid_after_block", obs_m_valid, 0);
    chk("s_ready_after_block", obs_s_ready, keys_ready);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int lat,
                           input bit bp);
    int p = en_pulses;
    next_ct  = ct;
    core_lat = lat;
    push_block(pt);
    chk("enc_en_start", obs_enc_en, 1);
    chk("enc_in_data", obs_in, pt);
    // First SEND cycle is START + 1 + lat + 1 negedges away.
    collect(ct, bp, lat + 2);
    chk("enc_en_once", en_pulses - p, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, ct;
    int  p, n;
    bit  mv;

    rst = 1'b1; keys_ready = 1'b1; sel = 1'b0; s_data = 8'h00; s_valid = 1'b0;
    m_ready = 1'b0; core_lat = 1; next_ct = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst0");
    sel = 1'b1;
    #1;
    chk_reset("rst1");
    sel = 1'b0;
    p = en_pulses;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("no_en_on_release", en_pulses - p, 0);
    chk("s_ready_idle", obs_s_ready, 1);
    chk("busy_idle", obs_busy, 0);

    // Directed block, 20-cycle core, no backpressure.
    run_block(128'h1122334455667700FFEEDDCCBBAA9988, 128'h7F679D90BEBC24305A468D42B9D4EDCD,
              20, 1'b0);
    // Minimum latency with backpressure, then random blocks.
    run_block(rnd128(), rnd128(), 1, 1'b1);
    for (int k = 0; k < 3; k++) run_block(rnd128(), rnd128(), $urandom_range(1, 30), 1'b1);

    // keys_ready low at reset, then a mid-block drop.
    keys_ready = 1'b0;
    do_reset();
    pt = rnd128();
    next_ct = rnd128();
    core_lat = 4;
    s_data = byte_of(pt, 0);
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("s_ready_keys_low", obs_s_ready, 0);
    end
    s_valid = 1'b0;
    chk("no_accept_keys_low", obs_busy, 0);
    keys_ready = 1'b1;
    for (int k = 0; k < 7; k++) push(byte_of(pt, k));
    keys_ready = 1'b0;
    s_data = byte_of(pt, 7);
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("s_ready_paused", obs_s_ready, 0);
      chk("busy_paused", obs_busy, 1);
    end
    s_valid = 1'b0;
    keys_ready = 1'b1;
    for (int k = 7; k < 16; k++) push(byte_of(pt, k));
    chk("enc_in_data_resumed", obs_in, pt);
    collect(next_ct, 1'b1, 6);

    // Asynchronous reset while waiting on the core.
    pt = rnd128();
    next_ct = rnd128();
    core_lat = 20;
    push_block(pt);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_wait");
    p = en_pulses;
    @(negedge clk);
    rst = 1'b0;
    mv = 1'b0;
    repeat (30) begin
      @(negedge clk);
      #1;
      mv |= obs_m_valid;
    end
    chk("no_en_after_rst", en_pulses - p, 0);
    chk("no_m_valid_after_rst", mv, 0);
    run_block(rnd128(), rnd128(), 3, 1'b1);

    // Asynchronous reset while presenting output byte 5.
    pt = rnd128();
    ct = rnd128();
    next_ct = ct;
    core_lat = 2;
    push_block(pt);
    m_ready = 1'b1;
    n = 0;
    while (!obs_m_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    chk("m_data_byte5", obs_m_data, byte_of(ct, 5));
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_send");
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_block(rnd128(), rnd128(), 1, 1'b0);

    // Timeout on the 16-cycle instance; ready only in the ignored first wait cycle.
    sel = 1'b1;
    #1;
    chk("dut1_idle_busy", obs_busy, 0);
    core_lat = 0;
    next_ct = rnd128();
    pt = rnd128();
    push_block(pt);
    chk("to_enc_en", obs_enc_en, 1);
    mv = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      #1;
      mv |= obs_m_valid;
      if (c == 16) begin
        chk("te_before_limit", obs_te, 0);
        chk("busy_before_limit", obs_busy, 1);
      end
    end
    chk("te_set", obs_te, 1);
    chk("busy_after_timeout", obs_busy, 0);
    chk("s_ready_after_timeout", obs_s_ready, 1);
    chk("no_m_valid_on_timeout", mv, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("te_sticky", obs_te, 1);
    run_block(rnd128(), rnd128(), 5, 1'b1);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
